// File: rtl/bcd_disp_pkg.sv
// Shared BCD types, constants and helpers for the scanned display front end.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    // Out-of-range codes (A..F) are pinned to the largest legal digit.
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the ripple carry/borrow chain: +1 on up, -1 on down.
// Purely combinational; up and down together leave the digit untouched.
module bcd_digit_cell
    import bcd_disp_pkg::*;
(
    input  bcd_t in,
    input  logic up,
    input  logic down,
    output bcd_t out,
    output logic carry_out,
    output logic borrow_out
);

    // Decimal increment/decrement with wrap and chain outputs.
    always_comb begin
        out        = in;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (up && !down) begin
            if (in == BCD_MAX) begin
                out       = BCD_ZERO;
                carry_out = 1'b1;
            end else begin
                out = in + 4'd1;
            end
        end else if (down && !up) begin
            if (in == BCD_ZERO) begin
                out        = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                out = in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit bus and
// one-hot anode select, feeding a single seven-segment decoder.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading-zero digits
// (anode forced off) except digit 0.
module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    ovf,
    output logic                    udf
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         step_val;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS:0]   borrow;

    // Chain entry: a lone inc or a lone dec injects one step at digit 0.
    assign carry[0]  = inc & ~dec;
    assign borrow[0] = dec & ~inc;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .in        (count_q[g*4 +: 4]),
            .up        (carry[g]),
            .down      (borrow[g]),
            .out       (step_val[g*4 +: 4]),
            .carry_out (carry[g+1]),
            .borrow_out(borrow[g+1])
        );
    end

    // Count priority: clr, then clamped load, then the +/-1 chain result.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                count_d[i*4 +: 4] = bcd_clamp(load_val[i*4 +: 4]);
            end
        end else begin
            count_d = step_val;
            ovf_d   = carry[NUM_DIGITS];
            udf_d   = borrow[NUM_DIGITS];
        end
    end

    // Free-running prescaler; slot advances on the prescaler's last count.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        slot_d  = slot_q;
        if (presc_q == PRESC_LAST) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end
        an_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (slot_d == SW'(i));
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            presc_q <= '0;
            slot_q  <= '0;
            an_q    <= NUM_DIGITS'(1);
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            presc_q <= presc_d;
            slot_q  <= slot_d;
            an_q    <= an_d;
        end
    end

    // Digit bus: the registered nibble under the current slot.
    always_comb begin
        digit = BCD_ZERO;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SW'(i)) begin
                digit = count_q[i*4 +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // lead_zero[i]: nibble i and everything above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (count_q[CW-1 -: 4] == BCD_ZERO);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (count_q[i*4 +: 4] == BCD_ZERO);
        end
    end

    // Blank the selected anode when it is a leading zero; digit 0 always lights.
    always_comb begin
        an = an_q;
        if (|(an_q & {lead_zero[NUM_DIGITS-1:1], 1'b0})) begin
            an = '0;
        end
    end
`else
    assign an = an_q;
`endif

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (NUM_DIGITS=4, SCAN_DIV=4).
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_bcd_scan_counter;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc = 1'b0, dec = 1'b0, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        ovf, udf;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain decimal value plus edge count since reset.
    int m_val = 0;
    bit m_ovf = 0;
    bit m_udf = 0;
    int m_cyc = 0;

    bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val), .count(count), .digit(digit), .an(an),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [15:0] b);
        int v, p, n;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            n = int'(b[i*4 +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_slot();
        return (m_cyc / SD) % ND;
    endfunction

    function automatic logic [3:0] exp_an();
        int s;
        logic [3:0] a;
        s = exp_slot();
        a = 4'(1 << s);
`ifdef LEADING_ZERO_BLANK_EN
        if (s != 0 && m_val < pow10(s)) a = 4'b0000;
`endif
        return a;
    endfunction

    function automatic logic [3:0] exp_digit();
        return 4'((m_val / pow10(exp_slot())) % 10);
    endfunction

    // Drive one cycle of controls, advance the model at the edge, settle 1 time unit.
    task automatic tick(input bit i, input bit d, input bit c, input bit l,
                        input logic [15:0] lv);
        inc = i; dec = d; clr = c; load = l; load_val = lv;
        @(posedge clk);
        m_ovf = 0;
        m_udf = 0;
        if (c) m_val = 0;
        else if (l) m_val = from_bcd_clamped(lv);
        else if (i && !d) begin
            if (m_val == 9999) begin m_val = 0; m_ovf = 1; end
            else m_val = m_val + 1;
        end else if (d && !i) begin
            if (m_val == 0) begin m_val = 9999; m_udf = 1; end
            else m_val = m_val - 1;
        end
        m_cyc = m_cyc + 1;
        #1;
    endtask

    task automatic model_reset();
        m_val = 0; m_ovf = 0; m_udf = 0; m_cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({count, an, digit, ovf, udf} !== {16'h0000, 4'b0001, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_init: got count=%h an=%b digit=%h ovf=%b udf=%b", count, an, digit, ovf, udf);
        end
        #7 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 7; k++) tick(1, 0, 0, 0, 16'h0);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (count !== 16'h0000) begin failures++; $display("FAIL reset_mid_count: got %h want 0000", count); end
        checks++;
        if (an !== 4'b0001) begin failures++; $display("FAIL reset_mid_an: got %b want 0001", an); end
        checks++;
        if (digit !== 4'h0) begin failures++; $display("FAIL reset_mid_digit: got %h want 0", digit); end
        checks++;
        if ({ovf, udf} !== 2'b00) begin failures++; $display("FAIL reset_mid_flags: got %b%b want 00", ovf, udf); end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_carry_chain();
        tick(0, 0, 0, 1, 16'h0199);
        checks++;
        if (count !== 16'h0199) begin failures++; $display("FAIL carry_load: got %h want 0199", count); end
        tick(1, 0, 0, 0, 16'h0);
        checks++;
        if ({count, ovf} !== {16'h0200, 1'b0}) begin
            failures++; $display("FAIL carry_inc: got %h ovf=%b want 0200 ovf=0", count, ovf);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 0, 0, 16'h0);
            checks++;
            if (count !== 16'h0200) begin failures++; $display("FAIL carry_incdec_hold: got %h want 0200", count); end
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 1, 16'h9999);
        tick(1, 0, 0, 0, 16'h0);
        checks++;
        if ({count, ovf, udf} !== {16'h0000, 1'b1, 1'b0}) begin
            failures++; $display("FAIL ovf_wrap: got %h ovf=%b udf=%b want 0000 1 0", count, ovf, udf);
        end
        tick(0, 0, 0, 0, 16'h0);
        checks++;
        if ({count, ovf} !== {16'h0000, 1'b0}) begin
            failures++; $display("FAIL ovf_pulse_end: got %h ovf=%b want 0000 0", count, ovf);
        end
        tick(0, 1, 0, 0, 16'h0);
        checks++;
        if ({count, ovf, udf} !== {16'h9999, 1'b0, 1'b1}) begin
            failures++; $display("FAIL udf_wrap: got %h ovf=%b udf=%b want 9999 0 1", count, ovf, udf);
        end
        tick(0, 0, 0, 0, 16'h0);
        checks++;
        if ({count, udf} !== {16'h9999, 1'b0}) begin
            failures++; $display("FAIL udf_pulse_end: got %h udf=%b want 9999 0", count, udf);
        end
    endtask

    task automatic test_priority_clamp();
        tick(1, 0, 1, 1, 16'h1234);
        checks++;
        if ({count, ovf, udf} !== {16'h0000, 1'b0, 1'b0}) begin
            failures++; $display("FAIL prio_clr: got %h ovf=%b udf=%b want 0000 0 0", count, ovf, udf);
        end
        tick(0, 0, 0, 1, 16'hF3A7);
        checks++;
        if (count !== 16'h9397) begin failures++; $display("FAIL load_clamp: got %h want 9397", count); end
        tick(0, 0, 0, 1, 16'h9999);
        tick(1, 0, 0, 1, 16'h0000);
        checks++;
        if ({count, ovf} !== {16'h0000, 1'b0}) begin
            failures++; $display("FAIL load_no_ovf: got %h ovf=%b want 0000 0", count, ovf);
        end
        tick(0, 1, 1, 0, 16'h0);
        checks++;
        if ({count, udf} !== {16'h0000, 1'b0}) begin
            failures++; $display("FAIL clr_no_udf: got %h udf=%b want 0000 0", count, udf);
        end
    endtask

    task automatic test_scan_order();
        int s;
        tick(0, 0, 0, 1, 16'h4321);
        for (int k = 0; k < 20; k++) begin
            tick(0, 0, 0, 0, 16'h0);
            s = exp_slot();
            checks++;
            if ({an, digit} !== {4'(1 << s), 4'(s + 1)}) begin
                failures++;
                $display("FAIL scan_order: cyc=%0d got an=%b digit=%h want an=%b digit=%h",
                         m_cyc, an, digit, 4'(1 << s), 4'(s + 1));
            end
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        int s;
        logic [3:0] want;
        tick(0, 0, 0, 1, 16'h0042);
        for (int k = 0; k < 16; k++) begin
            tick(0, 0, 0, 0, 16'h0);
            s = exp_slot();
            want = (s >= 2) ? 4'b0000 : 4'(1 << s);
            checks++;
            if ({an, digit} !== {want, exp_digit()}) begin
                failures++;
                $display("FAIL blank_0042: slot=%0d got an=%b digit=%h want an=%b digit=%h",
                         s, an, digit, want, exp_digit());
            end
        end
        tick(0, 0, 1, 0, 16'h0);
        for (int k = 0; k < 16; k++) begin
            tick(0, 0, 0, 0, 16'h0);
            s = exp_slot();
            want = (s == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if ({an, digit} !== {want, 4'h0}) begin
                failures++;
                $display("FAIL blank_zero: slot=%0d got an=%b digit=%h want an=%b digit=0", s, an, digit, want);
            end
        end
    endtask
`endif

    task automatic test_random();
        int r;
        logic [15:0] lv;
        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 15);
            lv = 16'($urandom());
            if (r == 0) lv = 16'h9999;
            if (r == 1) lv = 16'h0000;
            tick(r inside {[2:8]} || r == 12, r inside {[9:12]} || r == 13,
                 r == 14, r <= 1 || r == 13 || r == 15, lv);
            checks++;
            if ({count, an, digit, ovf, udf} !== {to_bcd(m_val), exp_an(), exp_digit(), m_ovf, m_udf}) begin
                failures++;
                $display("FAIL random_step%0d: got count=%h an=%b digit=%h ovf=%b udf=%b want count=%h an=%b digit=%h ovf=%b udf=%b",
                         k, count, an, digit, ovf, udf,
                         to_bcd(m_val), exp_an(), exp_digit(), m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_wrap();
        test_priority_clamp();
        test_scan_order();
`ifdef LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Upstream stage of the seven-segment decoder.
- Holds a NUM_DIGITS-wide BCD up/down counter and time-multiplexes its digits onto one 4-bit digit bus {w,x,y,z}, with a one-hot digit-select (anode) vector.
- The digit bus feeds the decoder directly, so one decoder drives a multi-digit display.

Parameters:
- NUM_DIGITS, 4, number of BCD digits held and scanned (legal range 2..8).
- SCAN_DIV, 1000, clocks each digit stays selected before the scan advances (legal value is 1 or more).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- inc  input  1  count up by one this cycle.
- dec  input  1  count down by one this cycle.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous load of load_val.
- load_val  input  4*NUM_DIGITS  BCD value to load; nibble 0 is least significant.
- count  output  4*NUM_DIGITS  current registered BCD value.
- digit  output  4  selected BCD digit; digit[3]=w, digit[2]=x, digit[1]=y, digit[0]=z.
- an  output  NUM_DIGITS  one-hot active-high digit select; an[i] means digit i is displayed.
- ovf  output  1  one-cycle pulse on wrap from all-9s to all-0s.
- udf  output  1  one-cycle pulse on wrap from all-0s to all-9s.

Behaviour:
- Reset: asserting rst clears the following immediately, regardless of clk, including mid-scan or mid-count:
  - count=0, prescaler=0, slot=0.
  - an=1 (digit 0 selected), digit=0, ovf=0, udf=0.
- Count update priority each clock, evaluated after reset:
  - clr sets count=0.
  - else load sets count=load_val, with any nibble >9 clamped to 9.
  - else inc&~dec gives +1; dec&~inc gives -1.
  - inc&dec together, or neither, holds count.
- Arithmetic is decimal per digit with a ripple carry/borrow chain, resolved in one cycle:
  - +1: nibble 9 becomes 0 and carries; any other nibble increments.
  - -1: nibble 0 becomes 9 and borrows; any other nibble decrements.
- Wrap and flags:
  - +1 from all-9s gives all-0s and ovf=1 for exactly the next cycle.
  - -1 from all-0s gives all-9s and udf=1 for exactly the next cycle.
  - clr and load never raise ovf or udf.
- Latency:
  - count reflects an operation one clock after the edge at which it is sampled.
  - ovf and udf are registered and align with that updated count.
- Scanner:
  - prescaler runs 0..SCAN_DIV-1, wraps, and is free-running (independent of inc/dec/clr/load).
  - When prescaler==SCAN_DIV-1, slot advances on the next edge; slot NUM_DIGITS-1 wraps to 0.
  - With SCAN_DIV=1, slot advances every clock.
- Outputs:
  - an is the registered one-hot decode of slot: exactly one bit set at all times after reset.
  - digit is a combinational mux of the registered count nibble[slot]. A count change therefore appears on digit in the same cycle count changes, if that nibble is selected.
- No combinational path from any input to any output.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When the selected nibble and every more-significant nibble are 0, an is driven all-zero for that slot (digit blank). digit still shows 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Slot timing is unchanged.
- Undefined: an is always one-hot, and all digits, including leading zeros, are displayed.

Decomposition:
- Package bcd_disp_pkg:
  - typedef bcd_t (logic [3:0]).
  - constants BCD_MAX=4'd9 and BCD_ZERO=4'd0.
  - function bcd_clamp(bcd_t) returning a value ≤9.
- Sub-module bcd_digit_cell, instantiated NUM_DIGITS times in the carry/borrow chain:
  - inputs: bcd_t in, up, down.
  - outputs: bcd_t out, carry_out, borrow_out.
  - purely combinational.
- Top level holds the registers, priority logic, prescaler, slot counter, one-hot decode, digit mux and the blanking logic.

Test Plan:
All scenarios use NUM_DIGITS=4 and SCAN_DIV=4.
- Reset mid-scan: after 7 clocks pulse rst asynchronously between edges -> immediately count=0000, an=0001, digit=0, ovf=udf=0.
- Carry chain: load 0x0199, then one inc -> count=0x0200 next cycle, ovf=0. Then inc&dec together for 3 cycles -> count stays 0x0200.
- Overflow/underflow:
  - load 0x9999, then inc -> count=0x0000 with ovf=1 for exactly one cycle.
  - Then dec -> count=0x9999 with udf=1 for one cycle.
- Priority and clamp: clr=1, load=1 (load_val=0x1234), inc=1 together -> count=0x0000. Then load 0xF3A7 -> count=0x9397.
- Scan order: count=0x4321 held -> an steps 0001→0010→0100→1000→0001, each held 4 clocks. digit shows 1,2,3,4 in step.
- LEADING_ZERO_BLANK_EN build with count=0x0042:
  - slots 2 and 3 show an=0000.
  - slots 0 and 1 show an=0001 with digit=2, then an=0010 with digit=4.
  - With count=0 only slot 0 lights.
